// File: rtl/stream_transposer.sv
// Streaming ROWxCOL matrix transposer: accepts one row per beat, emits one column per beat.
// Define STREAM_TRANSPOSER_PINGPONG_EN for two banks, so one matrix fills while the previous drains.
module stream_transposer #(
  parameter int IL  = 8,
  parameter int FL  = 12,
  parameter int ROW = 4,
  parameter int COL = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COL-1:0][IL+FL-1:0]     in_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ROW-1:0][IL+FL-1:0]     out_col,
  output logic                          out_last,
  output logic [1:0]                    state
);

  localparam int W  = IL + FL;
`ifdef STREAM_TRANSPOSER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);

  logic [COL-1:0][W-1:0] r_mem [NB][ROW];
  logic [NB-1:0]         r_full;
  logic [RW-1:0]         r_wr_row;
  logic [CW-1:0]         r_rd_col;
  logic                  r_wr_bank;
  logic                  r_rd_bank;

  logic                  w_in_acc;
  logic                  w_out_xfer;
  logic                  w_wr_last;
  logic                  w_rd_last;
  logic                  w_wr_bank_nxt;
  logic                  w_rd_bank_nxt;

  // Handshakes occurring in a flush cycle are discarded.
  assign in_ready      = !r_full[r_wr_bank];
  assign out_valid     = r_full[r_rd_bank];
  assign w_in_acc      = in_valid && in_ready && !flush;
  assign w_out_xfer    = out_valid && out_ready && !flush;
  assign w_wr_last     = (r_wr_row == ROW_LAST);
  assign w_rd_last     = (r_rd_col == COL_LAST);
  assign w_wr_bank_nxt = (NB == 2) ? ~r_wr_bank : 1'b0;
  assign w_rd_bank_nxt = (NB == 2) ? ~r_rd_bank : 1'b0;
  assign out_last      = out_valid && w_rd_last;
  assign state         = {out_valid, (r_wr_row != '0)};

  // Fill and drain always complete on different banks, so both updates may land on one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full    <= '0;
      r_wr_row  <= '0;
      r_rd_col  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else if (flush) begin
      r_full    <= '0;
      r_wr_row  <= '0;
      r_rd_col  <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_in_acc) begin
        if (w_wr_last) begin
          r_wr_row          <= '0;
          r_wr_bank         <= w_wr_bank_nxt;
          r_full[r_wr_bank] <= 1'b1;
        end else begin
          r_wr_row <= r_wr_row + RW'(1);
        end
      end
      if (w_out_xfer) begin
        if (w_rd_last) begin
          r_rd_col          <= '0;
          r_rd_bank         <= w_rd_bank_nxt;
          r_full[r_rd_bank] <= 1'b0;
        end else begin
          r_rd_col <= r_rd_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < ROW; r++) begin
          r_mem[b][r] <= '0;
        end
      end
    end else if (flush) begin
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < ROW; r++) begin
          r_mem[b][r] <= '0;
        end
      end
    end else if (w_in_acc) begin
      r_mem[r_wr_bank][r_wr_row] <= in_row;
    end
  end

  // Column select; forced to zero while no matrix is ready.
  always_comb begin
    out_col = '0;
    if (out_valid) begin
      for (int r = 0; r < ROW; r++) begin
        out_col[r] = r_mem[r_rd_bank][r][r_rd_col];
      end
    end
  end

endmodule

// File: tb/tb_stream_transposer.sv
// Directed bench for stream_transposer: a 4x4 instance and a 3x5 instance sharing clock and reset.
module tb_stream_transposer;

`ifdef STREAM_TRANSPOSER_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0][19:0]  in_row;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][19:0]  out_col;
  logic              out_last;
  logic [1:0]        state;

  logic              flush2;
  logic              in_valid2;
  logic              in_ready2;
  logic [4:0][19:0]  in_row2;
  logic              out_valid2;
  logic              out_ready2;
  logic [2:0][19:0]  out_col2;
  logic              out_last2;
  logic [1:0]        state2;

  int n_chk = 0;
  int n_err = 0;

  logic [19:0] m6 [3][5];

  stream_transposer #(.IL(8), .FL(12), .ROW(4), .COL(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_last(out_last), .state(state)
  );

  stream_transposer #(.IL(8), .FL(12), .ROW(3), .COL(5)) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_row(in_row2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_col(out_col2),
    .out_last(out_last2), .state(state2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r of a 4x4 matrix with A[r][c] = base + 16r + c.
  function automatic logic [79:0] row4(input int base, input int r);
    logic [79:0] v;
    for (int c = 0; c < 4; c++) v[c*20 +: 20] = 20'(base + 16*r + c);
    return v;
  endfunction

  // Expected output beat k of the same matrix: element r = base + 16r + k.
  function automatic logic [79:0] beat4(input int base, input int k);
    logic [79:0] v;
    for (int r = 0; r < 4; r++) v[r*20 +: 20] = 20'(base + 16*r + k);
    return v;
  endfunction

  initial begin
    int sent, beats, low, saw;
    logic acc, xf;
    logic [59:0] e6;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
    flush2 = 1'b0; in_valid2 = 1'b0; in_row2 = '0; out_ready2 = 1'b0;
    m6[0][0] = 20'hFFFFF; m6[0][1] = 20'h80000; m6[0][2] = 20'h00000; m6[0][3] = 20'h7FFFF; m6[0][4] = 20'h00001;
    m6[1][0] = 20'h12345; m6[1][1] = 20'hFFFFE; m6[1][2] = 20'h80001; m6[1][3] = 20'h00010; m6[1][4] = 20'hABCDE;
    m6[2][0] = 20'h00000; m6[2][1] = 20'h7FFFF; m6[2][2] = 20'hFFFFF; m6[2][3] = 20'h80000; m6[2][4] = 20'h55555;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_state", state, 2'b00);
    chk("rst_out_col", out_col, '0);

    // Test 1: async reset in the middle of a fill
    in_valid = 1'b1; in_row = row4(0, 0); tick();
    in_row = row4(0, 1); tick();
    in_valid = 1'b0;
    chk("fill2_state", state, 2'b01);
    chk("fill2_out_valid", out_valid, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_out_col", out_col, '0);
    chk("async_rst_state", state, 2'b00);
    #1 reset_n = 1'b1;
    tick();

    // Test 2: basic 4x4 transpose, consumer always ready
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_row = row4(0, r);
      chk("basic_no_early_valid", out_valid, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_col", out_col, beat4(0, k));
      chk("basic_last", out_last, (k == 3));
      tick();
    end
    chk("basic_drained", out_valid, 1'b0);
    chk("basic_state_idle", state, 2'b00);

    // Test 3: backpressure on beat 1
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_row = row4(32'h100, r);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_beat0", out_col, beat4(32'h100, 0));
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_col", out_col, beat4(32'h100, 1));
      tick();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      chk("bp_col", out_col, beat4(32'h100, k));
      chk("bp_last", out_last, (k == 3));
      tick();
    end
    chk("bp_drained", out_valid, 1'b0);

    // Test 4: three matrices offered back to back
    sent = 0; beats = 0; low = 0; saw = 0;
    for (int cyc = 0; cyc < 40 && beats < 12; cyc++) begin
      if (out_valid) begin
        chk("b2b_col", out_col, beat4(32'h400 * (beats / 4 + 1), beats % 4));
        chk("b2b_last", out_last, ((beats % 4) == 3));
      end
      if (!in_ready && sent < 12) low++;
      if (state == 2'b11) saw = 1;
      in_valid = (sent < 12);
      in_row = row4(32'h400 * (sent / 4 + 1), sent % 4);
      acc = in_valid && in_ready;
      xf = out_valid && out_ready;
      tick();
      if (acc) sent++;
      if (xf) beats++;
    end
    in_valid = 1'b0;
    chk("b2b_beats", beats, 12);
    chk("b2b_in_ready_low_cycles", low, PP ? 0 : 8);
    chk("b2b_saw_state11", saw, PP ? 1 : 0);

    // Test 5: fill until stalled, then flush
    out_ready = 1'b0; sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!in_ready) break;
      in_valid = 1'b1; in_row = row4(32'h800, sent % 4);
      tick();
      sent++;
    end
    in_valid = 1'b0;
    chk("full_rows_accepted", sent, PP ? 8 : 4);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_state", state, 2'b10);
    flush = 1'b1; in_valid = 1'b1; in_row = row4(32'h900, 0); out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_state", state, 2'b00);
    chk("flush_out_col", out_col, '0);
    chk("flush_out_last", out_last, 1'b0);
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1; in_row = row4(32'hA0000, r);
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("postflush_valid", out_valid, 1'b1);
      chk("postflush_col", out_col, beat4(32'hA0000, k));
      chk("postflush_last", out_last, (k == 3));
      tick();
    end
    chk("postflush_drained", out_valid, 1'b0);

    // Test 6: 3x5 instance with signed extremes
    chk("ns_idle_ready", in_ready2, 1'b1);
    chk("ns_idle_state", state2, 2'b00);
    out_ready2 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      in_valid2 = 1'b1;
      for (int c = 0; c < 5; c++) in_row2[c] = m6[r][c];
      tick();
    end
    in_valid2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int r = 0; r < 3; r++) e6[r*20 +: 20] = m6[r][k];
      chk("ns_valid", out_valid2, 1'b1);
      chk("ns_col", out_col2, e6);
      chk("ns_last", out_last2, (k == 4));
      if (k == 1) chk("ns_col1_literal", out_col2, 60'h7FFFF_FFFFE_80000);
      tick();
    end
    chk("ns_drained", out_valid2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
